// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared definitions for the 4:1 tristate-mux select arbiter.
//   N_REQ  - number of requesters (one per mux data input)
//   SEL_W  - width of the mux select encoding
//   state_t - arbiter FSM states
//   onehot_to_idx - converts a one-hot grant vector to its select index
package mux_sel_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // A zero vector maps to index 0; callers qualify the result with a valid flag.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_pick.sv
// rr_pick4: combinational round-robin priority picker.
//   req      [3:0] in  - level requests
//   last_ptr [1:0] in  - most recently granted requester
//   any            out - at least one request is asserted
//   idx      [1:0] out - index of the chosen requester
//   onehot   [3:0] out - one-hot form of idx (zero when any=0)
// Scanning starts at last_ptr+1 and wraps, so the previous owner ranks last.
module rr_pick4
  import mux_sel_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any    = 1'b0;
    onehot = '0;
    cand   = '0;
    // Offset N_REQ wraps back to last_ptr itself, letting a lone previous owner win.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
      end
    end
    idx = onehot_to_idx(onehot);
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter driving the select pair and output enable
// of a 4:1 tristate mux, with bounded hold time and one dead cycle between owners.
//   clk        in        - clock, rising edge
//   rst_n      in        - asynchronous active-low reset
//   req   [3:0] in       - level requests, bit i owns mux input Ii
//   gnt   [3:0] out      - registered one-hot grant
//   S0, S1     out       - registered mux select (S1 is MSB)
//   sel_valid  out       - mux output enable, high while a grant is active
//   busy       out       - high in GRANT or TURN
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             S0,
  output logic             S1,
  output logic             sel_valid,
  output logic             busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t           state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SEL_W-1:0] last_ptr;
  logic [SEL_W-1:0] sel;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;

  logic             owner_release;
  logic             others_waiting;
  logic             timed_out;

  rr_pick4 u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .any      (pick_any),
    .idx      (pick_idx),
    .onehot   (pick_oh)
  );

  // In GRANT, gnt is the owner's one-hot, so it masks the owner's request bit.
  assign owner_release  = ~|(req & gnt);
  assign others_waiting = |(req & ~gnt);
  assign timed_out      = (hold_cnt == HOLD_LAST);

  assign S0 = sel[0];
  assign S1 = sel[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      hold_cnt  <= '0;
      last_ptr  <= SEL_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE, TURN: begin
          if (pick_any) begin
            state     <= GRANT;
            gnt       <= pick_oh;
            sel       <= pick_idx;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            last_ptr  <= pick_idx;
            hold_cnt  <= '0;
          end else begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        GRANT: begin
          if (owner_release || (timed_out && others_waiting)) begin
            // Dead cycle: output goes high-Z, select holds to avoid a glitch.
            state     <= TURN;
            gnt       <= '0;
            sel_valid <= 1'b0;
            hold_cnt  <= '0;
          end else if (!timed_out) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          sel       <= '0;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
